ks_add_arbiter: RTL and testbench
=================================

// Module: ks_add_arbiter
// PURPOSE
//  Shares one pipelined 16-bit Kogge-Stone adder (ks_16b_pipe, LAT register stages) among
//  N_REQ butterfly requesters in the FFT datapath. Round-robin grant, valid/ready accept.
//  Drives the adder's operands and carry-in, tags each op with its requester id, and routes
//  the sum back as a one-hot response. Global stall freezes arbiter, tag pipe and adder.
// PARAMETERS
//  W      16  operand/sum width
//  N_REQ  4   number of requesters (>=2)
//  LAT    5   adder pipeline depth, edges from operand capture to valid i_add_sum
//  IDW    2   requester id width, = clog2(N_REQ)
// PORTS
//  i_clk        in   1         clock, all state on rising edge
//  i_rst_n      in   1         asynchronous active-low reset
//  i_stall      in   1         global freeze (FFT stall)
//  i_flush      in   1         synchronous: discard all in-flight ops
//  i_req_valid  in   N_REQ     per-requester request
//  i_req_a      in   N_REQ*W   operand A, requester k at [k*W +: W]
//  i_req_b      in   N_REQ*W   operand B, same packing
//  i_req_cin    in   N_REQ     carry-in (1 with inverted B = subtract)
//  o_req_ready  out  N_REQ     one-hot grant, combinational
//  o_add_a      out  W         registered operand A to adder
//  o_add_b      out  W         registered operand B to adder
//  o_add_cin    out  1         registered carry-in to adder
//  o_add_en     out  1         adder pipeline enable, = ~i_stall
//  i_add_sum    in   W         adder sum, LAT enabled edges after capture
//  i_add_cout   in   1         adder carry-out, aligned with i_add_sum
//  o_rsp_valid  out  N_REQ     one-hot response strobe, one cycle
//  o_rsp_sum    out  W         registered sum
//  o_rsp_cout   out  1         registered carry-out
//  o_rsp_id     out  IDW       id of responding requester
//  o_inflight   out  clog2(LAT+3)  ops accepted, response not yet issued
// BEHAVIOUR
//  Reset values: all outputs and registers 0; rr pointer = 0; o_req_ready = 0 during reset.
//  Arbiter:
//   - Grant is combinational, round-robin.
//   - Search order is ptr, ptr+1, ... mod N_REQ. The first valid requester gets o_req_ready.
//   - No grant when i_stall or i_flush is high.
//   - Accept = valid & ready. On accept, ptr <= granted id + 1 (mod N_REQ); otherwise ptr holds.
//   - A requester keeps valid and its operands stable until it sees ready (team rule).
//  Issue:
//   - On an accept edge, o_add_a/b/cin latch the granted operands.
//   - A stage-0 tag {vld=1, id} enters the tag pipe.
//   - An idle cycle inserts a bubble (vld=0). o_add_* hold their value; the adder ignores it.
//  Tag pipe:
//   - LAT+1 entries {vld, id}; advances only when ~i_stall.
//   - Its tail aligns with i_add_sum.
//  Response:
//   - When the tail vld=1 and ~i_stall, the next edge registers sum/cout/id and sets o_rsp_valid[id].
//   - o_rsp_valid is otherwise 0 and is a single-cycle pulse.
//   - Requesters cannot back-pressure.
//  Latency:
//   - Accept edge at T; o_rsp_valid high in the cycle after edge T+LAT+1.
//   - Each stalled cycle adds exactly 1 cycle.
//  Throughput: 1 op/cycle sustained. All N_REQ valid -> grants rotate 0,1,2,3,0...
//  o_inflight:
//   - +1 on accept, -1 on response issue; unchanged if both happen in the same cycle.
//   - Max LAT+2; never wraps.
//  Stall:
//   - Freezes ptr, tag pipe, o_add_*, o_rsp_* and o_inflight.
//   - o_rsp_valid drops to 0 during the stall; the pending response fires after release, never twice.
//  Flush:
//   - Takes priority over accept and response.
//   - Next edge clears all tag vld, o_rsp_valid and o_inflight; ptr holds.
//   - Flush during stall still clears.
//  Reset mid-operation: all in-flight ops are lost with no response. The first grant after
//  reset goes to requester 0 if valid.
//  Arithmetic: no width conversion here. Sum is W bits plus cout, exactly as the adder delivers.
// STRUCTURE
//  Package ks_arb_pkg: W, N_REQ, LAT, IDW defaults; typedef tag_t {logic vld; logic [IDW-1:0] id}.
//  Sub-module ks_tag_pipe: LAT+1 deep shift register of tag_t with enable and synchronous clear.
//  Round-robin grant logic stays inline (priority rotate over 2*N_REQ bits).
// TESTING
//  1) Only req1 valid, A=0x1234, B=0x0FF0, cin=0.
//     -> ready[1] same cycle; rsp_valid=4'b0010, sum=0x2224, cout=0 at T+7.
//  2) All 4 valid for 8 cycles.
//     -> grants 0,1,2,3,0,1,2,3; back-to-back responses in the same order; o_inflight peaks at 7.
//  3) Subtract: A=0x0005, B=~0x0007, cin=1.
//     -> sum=0xFFFE, cout=0. Also A=0xFFFF, B=0x0001, cin=0 -> sum=0x0000, cout=1.
//  4) i_stall high 3 cycles while 4 ops are in flight.
//     -> no grant and o_add_en=0 during the stall; responses arrive 3 cycles late, none lost or duplicated.
//  5) i_flush with 5 ops in flight, then one new op.
//     -> no responses for the flushed ops; o_inflight=0; the new op returns normally at T+7.
//  6) i_rst_n low mid-burst, then release.
//     -> all outputs 0; no stale responses; first grant to requester 0.

Source files
------------

// File: rtl/ks_arb_pkg.sv
// rtl/ks_arb_pkg.sv - shared sizes and tag type for the Kogge-Stone adder arbiter
package ks_arb_pkg;

  localparam int W     = 16;
  localparam int N_REQ = 4;
  localparam int LAT   = 5;
  localparam int IDW   = $clog2(N_REQ);

  typedef struct packed {
    logic           vld;
    logic [IDW-1:0] id;
  } tag_t;

endpackage

// File: rtl/ks_tag_pipe.sv
// rtl/ks_tag_pipe.sv - requester-id tag shift register that shadows the adder pipeline
module ks_tag_pipe
  import ks_arb_pkg::*;
#(
  parameter int DEPTH = LAT + 1
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_en,
  input  logic i_clr,
  input  tag_t i_tag,
  output tag_t o_tail
);

  tag_t [DEPTH-1:0] pipe_q;
  tag_t [DEPTH-1:0] pipe_d;

  // Clear wins over enable so a flush still lands while the datapath is stalled.
  always_comb begin
    pipe_d = pipe_q;
    if (i_clr) begin
      pipe_d = '0;
    end else if (i_en) begin
      pipe_d = {pipe_q[DEPTH-2:0], i_tag};
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pipe_q <= '0;
    end else begin
      pipe_q <= pipe_d;
    end
  end

  assign o_tail = pipe_q[DEPTH-1];

endmodule

// File: rtl/ks_add_arbiter.sv
// rtl/ks_add_arbiter.sv - round-robin sharing of one pipelined 16-bit adder among FFT requesters
module ks_add_arbiter #(
  parameter int W     = ks_arb_pkg::W,
  parameter int N_REQ = ks_arb_pkg::N_REQ,
  parameter int LAT   = ks_arb_pkg::LAT,
  parameter int IDW   = ks_arb_pkg::IDW
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_stall,
  input  logic                     i_flush,
  input  logic [N_REQ-1:0]         i_req_valid,
  input  logic [N_REQ*W-1:0]       i_req_a,
  input  logic [N_REQ*W-1:0]       i_req_b,
  input  logic [N_REQ-1:0]         i_req_cin,
  output logic [N_REQ-1:0]         o_req_ready,
  output logic [W-1:0]             o_add_a,
  output logic [W-1:0]             o_add_b,
  output logic                     o_add_cin,
  output logic                     o_add_en,
  input  logic [W-1:0]             i_add_sum,
  input  logic                     i_add_cout,
  output logic [N_REQ-1:0]         o_rsp_valid,
  output logic [W-1:0]             o_rsp_sum,
  output logic                     o_rsp_cout,
  output logic [IDW-1:0]           o_rsp_id,
  output logic [$clog2(LAT+3)-1:0] o_inflight
);
  import ks_arb_pkg::tag_t;

  localparam int INFW = $clog2(LAT + 3);

  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [N_REQ-1:0] rot;
  logic             accept;
  int               grant_idx, next_idx;
  logic [IDW-1:0]   grant_id;
  logic [N_REQ-1:0] grant_oh;

  logic [W-1:0]     add_a_q, add_a_d, add_b_q, add_b_d;
  logic             add_cin_q, add_cin_d;

  tag_t             tag_in, tail;
  logic             rsp_fire;
  logic [N_REQ-1:0] rsp_valid_q, rsp_valid_d;
  logic [W-1:0]     rsp_sum_q, rsp_sum_d;
  logic             rsp_cout_q, rsp_cout_d;
  logic [IDW-1:0]   rsp_id_q, rsp_id_d;
  logic [INFW-1:0]  inflight_q, inflight_d;

  // Rotate valids so bit 0 is the pointer position; lowest set bit wins.
  always_comb begin
    rot       = N_REQ'({i_req_valid, i_req_valid} >> ptr_q);
    accept    = |rot;
    grant_idx = 0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (rot[k]) grant_idx = int'(ptr_q) + k;
    end
    if (grant_idx >= N_REQ) grant_idx = grant_idx - N_REQ;
    if (i_stall || i_flush || !i_rst_n) accept = 1'b0;
    grant_id  = IDW'(grant_idx);
    grant_oh  = accept ? (N_REQ'(1) << grant_id) : '0;
    next_idx  = grant_idx + 1;
    if (next_idx >= N_REQ) next_idx = 0;
    ptr_d     = accept ? IDW'(next_idx) : ptr_q;
    add_a_d   = accept ? i_req_a[grant_idx*W +: W] : add_a_q;
    add_b_d   = accept ? i_req_b[grant_idx*W +: W] : add_b_q;
    add_cin_d = accept ? i_req_cin[grant_idx] : add_cin_q;
    tag_in    = '{vld: accept, id: grant_id};
  end

  ks_tag_pipe #(
    .DEPTH (LAT + 1)
  ) u_tag_pipe (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_en    (~i_stall),
    .i_clr   (i_flush),
    .i_tag   (tag_in),
    .o_tail  (tail)
  );

  // A response counts as issued in the cycle it is visible, hence the decrement uses rsp_valid_q.
  assign rsp_fire = |rsp_valid_q;

  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_sum_d   = rsp_sum_q;
    rsp_cout_d  = rsp_cout_q;
    rsp_id_d    = rsp_id_q;
    inflight_d  = inflight_q;
    if (i_flush) begin
      rsp_valid_d = '0;
      inflight_d  = '0;
    end else if (!i_stall) begin
      rsp_valid_d = tail.vld ? (N_REQ'(1) << tail.id) : '0;
      if (tail.vld) begin
        rsp_sum_d  = i_add_sum;
        rsp_cout_d = i_add_cout;
        rsp_id_d   = tail.id;
      end
      case ({accept, rsp_fire})
        2'b10:   inflight_d = inflight_q + INFW'(1);
        2'b01:   inflight_d = inflight_q - INFW'(1);
        default: inflight_d = inflight_q;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ptr_q       <= '0;
      add_a_q     <= '0;
      add_b_q     <= '0;
      add_cin_q   <= 1'b0;
      rsp_valid_q <= '0;
      rsp_sum_q   <= '0;
      rsp_cout_q  <= 1'b0;
      rsp_id_q    <= '0;
      inflight_q  <= '0;
    end else begin
      ptr_q       <= ptr_d;
      add_a_q     <= add_a_d;
      add_b_q     <= add_b_d;
      add_cin_q   <= add_cin_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_sum_q   <= rsp_sum_d;
      rsp_cout_q  <= rsp_cout_d;
      rsp_id_q    <= rsp_id_d;
      inflight_q  <= inflight_d;
    end
  end

  assign o_req_ready = grant_oh;
  assign o_add_a     = add_a_q;
  assign o_add_b     = add_b_q;
  assign o_add_cin   = add_cin_q;
  assign o_add_en    = ~i_stall & i_rst_n;
  // A pending strobe is held through a stall and shown once after release.
  assign o_rsp_valid = rsp_valid_q & {N_REQ{~i_stall}};
  assign o_rsp_sum   = rsp_sum_q;
  assign o_rsp_cout  = rsp_cout_q;
  assign o_rsp_id    = rsp_id_q;
  assign o_inflight  = inflight_q;

endmodule

// File: tb/tb_ks_add_arbiter.sv
// tb/tb_ks_add_arbiter.sv - scoreboard bench for ks_add_arbiter with a behavioural pipelined adder
module tb_ks_add_arbiter;
  import ks_arb_pkg::*;

  localparam int INFW = $clog2(LAT + 3);

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 stall = 1'b0;
  logic                 flush = 1'b0;
  logic [N_REQ-1:0]     rv = '0;
  logic [N_REQ-1:0]     rcin = '0;
  logic [N_REQ*W-1:0]   ra = '0;
  logic [N_REQ*W-1:0]   rb = '0;
  logic [N_REQ-1:0]     o_req_ready;
  logic [W-1:0]         add_a, add_b, add_sum;
  logic                 add_cin, add_en, add_cout;
  logic [N_REQ-1:0]     o_rsp_valid;
  logic [W-1:0]         o_rsp_sum;
  logic                 o_rsp_cout;
  logic [IDW-1:0]       o_rsp_id;
  logic [INFW-1:0]      o_inflight;
  logic [W:0]           pipe [LAT];

  typedef struct {
    int         id;
    logic [W-1:0] sum;
    logic       cout;
    int         due;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  int   act = 0;
  int   rsp_cnt = 0;

  ks_add_arbiter dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_stall     (stall),
    .i_flush     (flush),
    .i_req_valid (rv),
    .i_req_a     (ra),
    .i_req_b     (rb),
    .i_req_cin   (rcin),
    .o_req_ready (o_req_ready),
    .o_add_a     (add_a),
    .o_add_b     (add_b),
    .o_add_cin   (add_cin),
    .o_add_en    (add_en),
    .i_add_sum   (add_sum),
    .i_add_cout  (add_cout),
    .o_rsp_valid (o_rsp_valid),
    .o_rsp_sum   (o_rsp_sum),
    .o_rsp_cout  (o_rsp_cout),
    .o_rsp_id    (o_rsp_id),
    .o_inflight  (o_inflight)
  );

  initial forever #5 clk = ~clk;

  // Behavioural LAT-stage adder with enable
  always @(posedge clk) begin
    if (add_en) begin
      pipe[0] <= {1'b0, add_a} + {1'b0, add_b} + {{W{1'b0}}, add_cin};
      for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
  end
  assign add_sum  = pipe[LAT-1][W-1:0];
  assign add_cout = pipe[LAT-1][W];

  // Count only un-stalled edges; response due time is measured in these
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) act <= 0;
    else if (!stall) act <= act + 1;
  end

  initial begin : monitor
    exp_t       e;
    int         gid;
    logic [W:0] s;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        q.delete();
      end else begin
        checks++;
        if (int'(o_inflight) != q.size()) begin
          errors++;
          $display("FAIL inflight: got %0d expected %0d", o_inflight, q.size());
        end
        if (o_rsp_valid != '0) begin
          rsp_cnt++;
          checks++;
          if (q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_rsp: got valid=%b expected no response", o_rsp_valid);
          end else begin
            e = q.pop_front();
            if (o_rsp_valid !== (N_REQ'(1) << e.id) || o_rsp_id !== IDW'(e.id) ||
                o_rsp_sum !== e.sum || o_rsp_cout !== e.cout || act != e.due) begin
              errors++;
              $display("FAIL rsp: got valid=%b id=%0d sum=%h cout=%b at=%0d expected id=%0d sum=%h cout=%b at=%0d",
                       o_rsp_valid, o_rsp_id, o_rsp_sum, o_rsp_cout, act, e.id, e.sum, e.cout, e.due);
            end
          end
        end
        if (flush) begin
          q.delete();
        end else if ((o_req_ready & rv) != '0) begin
          gid = 0;
          for (int k = 0; k < N_REQ; k++) if (o_req_ready[k]) gid = k;
          s = {1'b0, ra[gid*W +: W]} + {1'b0, rb[gid*W +: W]} + {{W{1'b0}}, rcin[gid]};
          e.id   = gid;
          e.sum  = s[W-1:0];
          e.cout = s[W];
          e.due  = act + LAT + 2;
          q.push_back(e);
        end
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation still running at time %0t", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int k, input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    ra[k*W +: W] = a;
    rb[k*W +: W] = b;
    rcin[k]      = c;
    rv[k]        = 1'b1;
  endtask

  task automatic set_rand(input int k);
    set_req(k, W'($urandom), W'($urandom), 1'($urandom_range(0, 1)));
  endtask

  task automatic drain(output int left);
    left = 60;
    while (left > 0 && q.size() != 0) begin
      @(negedge clk);
      #1;
      left--;
    end
  endtask

  task automatic wait_rsp(output int n);
    bit found;
    found = 1'b0;
    n = 99;
    for (int i = 1; i <= 20 && !found; i++) begin
      @(negedge clk);
      if (o_rsp_valid != '0) begin
        found = 1'b1;
        n = i;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    rv = '1;
    repeat (2) step();
    @(negedge clk);
    checks++;
    if (o_req_ready !== '0) begin errors++; $display("FAIL reset_ready: got %b expected 0", o_req_ready); end
    checks++;
    if ({add_a, add_b, add_cin} !== '0 || add_en !== 1'b0) begin
      errors++; $display("FAIL reset_add: got a=%h b=%h cin=%b en=%b expected all 0", add_a, add_b, add_cin, add_en);
    end
    checks++;
    if (o_rsp_valid !== '0 || o_rsp_sum !== '0 || o_rsp_cout !== 1'b0 || o_rsp_id !== '0) begin
      errors++; $display("FAIL reset_rsp: got v=%b sum=%h cout=%b id=%0d expected all 0", o_rsp_valid, o_rsp_sum, o_rsp_cout, o_rsp_id);
    end
    checks++;
    if (o_inflight !== '0) begin errors++; $display("FAIL reset_inflight: got %0d expected 0", o_inflight); end
    step();
    rv = '0;
    rst_n = 1'b1;
  endtask

  task automatic test_back_to_back();
    int t0, peak, left;
    peak = 0;
    t0 = rsp_cnt;
    step();
    for (int k = 0; k < N_REQ; k++) set_rand(k);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checks++;
      if (o_req_ready !== (N_REQ'(1) << (i % N_REQ))) begin
        errors++; $display("FAIL b2b_grant[%0d]: got %b expected %b", i, o_req_ready, N_REQ'(1) << (i % N_REQ));
      end
      if (int'(o_inflight) > peak) peak = int'(o_inflight);
      step();
      set_rand(i % N_REQ);
    end
    rv = '0;
    left = 60;
    while (left > 0 && q.size() != 0) begin
      @(negedge clk);
      #1;
      if (int'(o_inflight) > peak) peak = int'(o_inflight);
      left--;
    end
    checks++;
    if (left == 0) begin errors++; $display("FAIL b2b_drain: got %0d pending expected 0", q.size()); end
    checks++;
    if (peak != LAT + 2) begin errors++; $display("FAIL b2b_peak: got %0d expected %0d", peak, LAT + 2); end
    checks++;
    if (rsp_cnt - t0 != 8) begin errors++; $display("FAIL b2b_count: got %0d expected 8", rsp_cnt - t0); end
  endtask

  task automatic test_single();
    int n, left;
    step();
    set_req(1, 16'h1234, 16'h0FF0, 1'b0);
    @(negedge clk);
    checks++;
    if (o_req_ready !== 4'b0010) begin errors++; $display("FAIL single_ready: got %b expected 0010", o_req_ready); end
    step();
    rv = '0;
    wait_rsp(n);
    checks++;
    if (n != LAT + 2) begin errors++; $display("FAIL single_latency: got %0d expected %0d", n, LAT + 2); end
    checks++;
    if (o_rsp_valid !== 4'b0010 || o_rsp_sum !== 16'h2224 || o_rsp_cout !== 1'b0) begin
      errors++; $display("FAIL single_rsp: got v=%b sum=%h cout=%b expected 0010 2224 0", o_rsp_valid, o_rsp_sum, o_rsp_cout);
    end
    drain(left);
  endtask

  task automatic test_arith();
    logic [W-1:0] ta [2];
    logic [W-1:0] tb [2];
    logic         tc [2];
    logic [W-1:0] es [2];
    logic         ec [2];
    int n, left;
    ta[0] = 16'h0005; tb[0] = ~16'h0007; tc[0] = 1'b1; es[0] = 16'hFFFE; ec[0] = 1'b0;
    ta[1] = 16'hFFFF; tb[1] = 16'h0001;  tc[1] = 1'b0; es[1] = 16'h0000; ec[1] = 1'b1;
    for (int t = 0; t < 2; t++) begin
      step();
      set_req(2 + t, ta[t], tb[t], tc[t]);
      @(negedge clk);
      step();
      rv = '0;
      wait_rsp(n);
      checks++;
      if (n != LAT + 2 || o_rsp_sum !== es[t] || o_rsp_cout !== ec[t]) begin
        errors++; $display("FAIL arith[%0d]: got sum=%h cout=%b after %0d expected sum=%h cout=%b after %0d",
                           t, o_rsp_sum, o_rsp_cout, n, es[t], ec[t], LAT + 2);
      end
      drain(left);
    end
  endtask

  task automatic test_stall();
    int t0, left;
    logic [N_REQ-1:0] g;
    t0 = rsp_cnt;
    step();
    for (int k = 0; k < N_REQ; k++) set_rand(k);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      g = o_req_ready;
      step();
      rv = rv & ~g;
    end
    repeat (3) step();
    stall = 1'b1;
    set_rand(0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (add_en !== 1'b0 || o_req_ready !== '0 || o_rsp_valid !== '0) begin
        errors++; $display("FAIL stall_freeze[%0d]: got en=%b ready=%b rsp=%b expected 0 0 0", i, add_en, o_req_ready, o_rsp_valid);
      end
      step();
    end
    stall = 1'b0;
    @(negedge clk);
    checks++;
    if (o_req_ready !== 4'b0001 || add_en !== 1'b1) begin
      errors++; $display("FAIL stall_release: got ready=%b en=%b expected 0001 1", o_req_ready, add_en);
    end
    step();
    rv = '0;
    drain(left);
    checks++;
    if (left == 0 || rsp_cnt - t0 != 5) begin
      errors++; $display("FAIL stall_count: got %0d responses (%0d pending) expected 5", rsp_cnt - t0, q.size());
    end
  endtask

  task automatic test_flush();
    int t0, n, left;
    logic [N_REQ-1:0] g;
    step();
    for (int k = 0; k < N_REQ; k++) set_rand(k);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      g = o_req_ready;
      step();
      for (int k = 0; k < N_REQ; k++) if (g[k]) set_rand(k);
    end
    flush = 1'b1;
    @(negedge clk);
    checks++;
    if (o_req_ready !== '0 || o_inflight !== INFW'(5)) begin
      errors++; $display("FAIL flush_cycle: got ready=%b inflight=%0d expected 0 5", o_req_ready, o_inflight);
    end
    step();
    flush = 1'b0;
    rv = '0;
    @(negedge clk);
    checks++;
    if (o_inflight !== '0 || o_rsp_valid !== '0) begin
      errors++; $display("FAIL flush_clear: got inflight=%0d rsp=%b expected 0 0", o_inflight, o_rsp_valid);
    end
    t0 = rsp_cnt;
    repeat (10) @(negedge clk);
    #1;
    checks++;
    if (rsp_cnt != t0) begin errors++; $display("FAIL flush_stale: got %0d responses expected 0", rsp_cnt - t0); end
    step();
    set_req(3, 16'h0100, 16'h0023, 1'b1);
    @(negedge clk);
    step();
    rv = '0;
    wait_rsp(n);
    checks++;
    if (n != LAT + 2 || o_rsp_valid !== 4'b1000 || o_rsp_sum !== 16'h0124) begin
      errors++; $display("FAIL flush_newop: got v=%b sum=%h after %0d expected 1000 0124 after %0d", o_rsp_valid, o_rsp_sum, n, LAT + 2);
    end
    drain(left);
  endtask

  task automatic test_reset_mid();
    int t0, left;
    logic [N_REQ-1:0] g;
    step();
    for (int k = 0; k < N_REQ; k++) set_rand(k);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      g = o_req_ready;
      step();
      for (int k = 0; k < N_REQ; k++) if (g[k]) set_rand(k);
    end
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if (o_req_ready !== '0 || add_en !== 1'b0 || add_a !== '0 || add_b !== '0 || o_inflight !== '0) begin
      errors++; $display("FAIL rstmid_out: got ready=%b en=%b a=%h b=%h infl=%0d expected all 0", o_req_ready, add_en, add_a, add_b, o_inflight);
    end
    checks++;
    if (o_rsp_valid !== '0 || o_rsp_sum !== '0 || o_rsp_id !== '0) begin
      errors++; $display("FAIL rstmid_rsp: got v=%b sum=%h id=%0d expected all 0", o_rsp_valid, o_rsp_sum, o_rsp_id);
    end
    repeat (2) step();
    rst_n = 1'b1;
    t0 = rsp_cnt;
    @(negedge clk);
    checks++;
    if (o_req_ready !== 4'b0001) begin errors++; $display("FAIL rstmid_first_grant: got %b expected 0001", o_req_ready); end
    step();
    rv = '0;
    drain(left);
    repeat (4) @(negedge clk);
    #1;
    checks++;
    if (left == 0 || rsp_cnt - t0 != 1) begin
      errors++; $display("FAIL rstmid_count: got %0d responses expected 1", rsp_cnt - t0);
    end
  endtask

  initial begin : main
    test_reset();
    test_back_to_back();
    test_single();
    test_arith();
    test_stall();
    test_flush();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
